// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by hazard_fwd_unit and hazard_ctrl.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        MDWAIT  = 2'd2,
        FAULT   = 2'd3
    } hz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_unit.sv
// E-stage operand forwarding select for one source register.
// The M-stage ALU result wins over the W-stage result; x0 is never forwarded.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       regwriteM,
    input  logic       regwriteW,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (regwriteM && rdM != 5'd0 && rdM == rs) begin
            fwd = FWD_M;
        end else if (regwriteW && rdW != 5'd0 && rdW == rs) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use stalls, branch flushes, mem/muldiv freezes.
// Define HAZARD_PERF_CNT_EN to build the stallcnt/flushcnt performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  rdE,
    input  logic [4:0]  rdM,
    input  logic [4:0]  rdW,
    input  logic        regwriteM,
    input  logic        regwriteW,
    input  logic [1:0]  resultsrcE,
    input  logic [1:0]  pcsrcE,
    input  logic        memreqM,
    input  logic        memackM,
    input  logic        mdvalidE,
    input  logic        mddone,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        mdstart,
    output logic        fault,
    output logic [31:0] stallcnt,
    output logic [31:0] flushcnt
);

    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    hz_state_e       state, state_nx;
    logic [TO_W-1:0] tocnt, tocnt_nx;
    logic            fault_q;
    logic            memstall, loaduse, redirect;
    logic            md_go;
    logic [1:0]      fwda, fwdb;
    // stall = {F,D,E,M}, flush = {D,E,M,W}
    logic [3:0]      stall, flush;

    assign memstall = memreqM && !memackM;
    assign redirect = pcsrcE != 2'b00;
    assign loaduse  = resultsrcE == RESULTSRC_LOAD && rdE != 5'd0 &&
                      (rdE == rs1D || rdE == rs2D);

    hazard_fwd_unit u_fwd_a (
        .rs        (rs1E),
        .rdM       (rdM),
        .rdW       (rdW),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .fwd       (fwda)
    );

    hazard_fwd_unit u_fwd_b (
        .rs        (rs2E),
        .rdM       (rdM),
        .rdW       (rdW),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .fwd       (fwdb)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= RUN;
            tocnt   <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nx;
            tocnt   <= tocnt_nx;
            fault_q <= fault_q | (state_nx == FAULT);
        end
    end

    always_comb begin
        state_nx = state;
        tocnt_nx = tocnt;
        stall    = 4'b0000;
        flush    = 4'b0000;
        md_go    = 1'b0;
        unique case (state)
            FAULT: begin
                stall = 4'b1111;
                flush = 4'b0001;
            end
            MDWAIT: begin
                if (mddone) begin
                    state_nx = RUN;
                end else begin
                    stall = 4'b1110;
                    flush = 4'b0010;
                end
            end
            default: begin
                // RUN, and MEMWAIT once the access completes, share one rule set
                if (memstall) begin
                    stall    = 4'b1111;
                    flush    = 4'b0001;
                    tocnt_nx = tocnt + TO_ONE;
                    if (state == RUN) begin
                        tocnt_nx = TO_ONE;
                        state_nx = (MEM_TIMEOUT <= 1) ? FAULT : MEMWAIT;
                    end else if (tocnt == TO_LAST) begin
                        state_nx = FAULT;
                    end
                end else if (mdvalidE) begin
                    md_go    = 1'b1;
                    stall    = 4'b1110;
                    flush    = 4'b0010;
                    state_nx = MDWAIT;
                end else begin
                    state_nx = RUN;
                    if (redirect) begin
                        flush = 4'b1100;
                    end else if (loaduse) begin
                        stall = 4'b1100;
                        flush = 4'b0100;
                    end
                end
            end
        endcase
    end

    assign {stallF, stallD, stallE, stallM} = RST ? 4'b0000 : stall;
    assign {flushD, flushE, flushM, flushW} = RST ? 4'b1111 : flush;
    assign mdstart   = !RST && md_go;
    assign forwardAE = RST ? FWD_RF : fwda;
    assign forwardBE = RST ? FWD_RF : fwdb;
    assign fault     = fault_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallcnt_q, flushcnt_q;
    logic        brflush;

    assign brflush = (state == RUN || state == MEMWAIT) &&
                     !memstall && !mdvalidE && redirect;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stallcnt_q <= 32'd0;
            flushcnt_q <= 32'd0;
        end else begin
            if (|stall) begin
                stallcnt_q <= stallcnt_q + 32'd1;
            end
            if (brflush) begin
                flushcnt_q <= flushcnt_q + 32'd1;
            end
        end
    end

    assign stallcnt = stallcnt_q;
    assign flushcnt = flushcnt_q;
`else
    assign stallcnt = 32'd0;
    assign flushcnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the combinational rules,
// hand-written sequences for memory wait, mul/div, timeout fault and counters.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic        CLK, RST;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic        regwriteM, regwriteW;
    logic [1:0]  resultsrcE, pcsrcE;
    logic        memreqM, memackM, mdvalidE, mddone;
    logic [1:0]  forwardAE, forwardBE;
    logic        stallF, stallD, stallE, stallM;
    logic        flushD, flushE, flushM, flushW;
    logic        mdstart, fault;
    logic [31:0] stallcnt, flushcnt;
    logic [3:0]  st, fl;

    int total  = 0;
    int passed = 0;

    hazard_ctrl #(.MEM_TIMEOUT(8), .TO_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .resultsrcE(resultsrcE), .pcsrcE(pcsrcE),
        .memreqM(memreqM), .memackM(memackM),
        .mdvalidE(mdvalidE), .mddone(mddone),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .mdstart(mdstart), .fault(fault),
        .stallcnt(stallcnt), .flushcnt(flushcnt)
    );

    assign st = {stallF, stallD, stallE, stallM};
    assign fl = {flushD, flushE, flushM, flushW};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] rs1E, rs2E, rdM, rdW;
        logic       rwM, rwW;
        logic [4:0] rs1D, rs2D, rdE;
        logic [1:0] rsrc, pcsrc;
        logic [1:0] eA, eB;
        logic [3:0] est, efl;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    task automatic idle();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        regwriteM = 0; regwriteW = 0; resultsrcE = 2'b00; pcsrcE = 2'b00;
        memreqM = 0; memackM = 0; mdvalidE = 0; mddone = 0;
    endtask

    task automatic loaduse_in();
        resultsrcE = RESULTSRC_LOAD; rdE = 5'd3; rs2D = 5'd3;
    endtask

    task automatic chk_ctl(input string nm, input logic [3:0] es,
                           input logic [3:0] ef);
        check({nm, "_stall"}, 32'(st), 32'(es));
        check({nm, "_flush"}, 32'(fl), 32'(ef));
    endtask

    initial begin
        vecs[0]  = '{5'd5, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0,
                     2'b00, 2'b00, 2'b10, 2'b00, 4'b0000, 4'b0000};
        vecs[1]  = '{5'd5, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0,
                     2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 4'b0000};
        vecs[2]  = '{5'd5, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0,
                     2'b00, 2'b00, 2'b01, 2'b01, 4'b0000, 4'b0000};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0,
                     2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000};
        vecs[4]  = '{5'd7, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0,
                     2'b00, 2'b00, 2'b10, 2'b10, 4'b0000, 4'b0000};
        vecs[5]  = '{5'd2, 5'd9, 5'd4, 5'd9, 1'b1, 1'b1, 5'd1, 5'd3, 5'd3,
                     2'b01, 2'b00, 2'b00, 2'b01, 4'b1100, 4'b0100};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd3, 5'd3,
                     2'b01, 2'b01, 2'b00, 2'b00, 4'b0000, 4'b1100};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
                     2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd3,
                     2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
                     2'b00, 2'b10, 2'b00, 2'b00, 4'b0000, 4'b1100};
        vecs[10] = '{5'd1, 5'd9, 5'd9, 5'd1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd9,
                     2'b01, 2'b00, 2'b01, 2'b10, 4'b1100, 4'b0100};

        idle();
        RST = 1'b1;
        regwriteM = 1; rdM = 5'd5; rs1E = 5'd5; mdvalidE = 1;
        @(negedge CLK); #2;
        chk_ctl("reset", 4'b0000, 4'b1111);
        check("reset_fwdA", 32'(forwardAE), 32'(FWD_RF));
        check("reset_mdstart", 32'(mdstart), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_stallcnt", stallcnt, 32'd0);
        check("reset_flushcnt", flushcnt, 32'd0);
        @(negedge CLK);
        idle();
        RST = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            rs1E = vecs[i].rs1E; rs2E = vecs[i].rs2E;
            rdM = vecs[i].rdM; rdW = vecs[i].rdW;
            regwriteM = vecs[i].rwM; regwriteW = vecs[i].rwW;
            rs1D = vecs[i].rs1D; rs2D = vecs[i].rs2D; rdE = vecs[i].rdE;
            resultsrcE = vecs[i].rsrc; pcsrcE = vecs[i].pcsrc;
            #2;
            check($sformatf("vec%0d_fwdA", i), 32'(forwardAE), 32'(vecs[i].eA));
            check($sformatf("vec%0d_fwdB", i), 32'(forwardBE), 32'(vecs[i].eB));
            chk_ctl($sformatf("vec%0d", i), vecs[i].est, vecs[i].efl);
        end

        // memory wait: 4 frozen cycles with a branch that must be ignored
        @(negedge CLK);
        idle();
        memreqM = 1; pcsrcE = 2'b01;
        #2;
        chk_ctl("mem_w0", 4'b1111, 4'b0001);
        for (int i = 1; i < 4; i++) begin
            @(negedge CLK); #2;
            chk_ctl($sformatf("mem_w%0d", i), 4'b1111, 4'b0001);
        end
        @(negedge CLK);
        memackM = 1; pcsrcE = 2'b00;
        #2;
        chk_ctl("mem_ack", 4'b0000, 4'b0000);
        @(negedge CLK);
        idle();
        #2;
        check("mem_state", 32'(dut.state), 32'(RUN));

        // mul/div: 6 stall cycles, released in the mddone cycle
        @(negedge CLK);
        mdvalidE = 1;
        #2;
        check("md_start0", 32'(mdstart), 32'd1);
        chk_ctl("md_c0", 4'b1110, 4'b0010);
        for (int i = 1; i < 6; i++) begin
            @(negedge CLK); #2;
            check($sformatf("md_start%0d", i), 32'(mdstart), 32'd0);
            chk_ctl($sformatf("md_c%0d", i), 4'b1110, 4'b0010);
        end
        @(negedge CLK);
        mddone = 1;
        #2;
        chk_ctl("md_done", 4'b0000, 4'b0000);
        check("md_done_start", 32'(mdstart), 32'd0);
        @(negedge CLK);
        idle();
        mddone = 1;
        loaduse_in();
        #2;
        check("md_state", 32'(dut.state), 32'(RUN));
        chk_ctl("md_run_done", 4'b1100, 4'b0100);

        // memory stall and mul/div together: memory goes first
        @(negedge CLK);
        idle();
        memreqM = 1; mdvalidE = 1;
        #2;
        check("mix_start_hold", 32'(mdstart), 32'd0);
        chk_ctl("mix_freeze", 4'b1111, 4'b0001);
        @(negedge CLK);
        memackM = 1;
        #2;
        check("mix_start", 32'(mdstart), 32'd1);
        chk_ctl("mix_ack", 4'b1110, 4'b0010);
        @(negedge CLK);
        memreqM = 0; memackM = 0; mddone = 1;
        #2;
        check("mix_state", 32'(dut.state), 32'(MDWAIT));
        chk_ctl("mix_done", 4'b0000, 4'b0000);

        // timeout: 8 unacknowledged wait cycles then sticky fault
        @(negedge CLK);
        idle();
        memreqM = 1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge CLK);
            #2;
            check($sformatf("to_fault%0d", i), 32'(fault), 32'd0);
            chk_ctl($sformatf("to_w%0d", i), 4'b1111, 4'b0001);
        end
        @(negedge CLK); #2;
        check("to_fault", 32'(fault), 32'd1);
        check("to_state", 32'(dut.state), 32'(FAULT));
        @(negedge CLK);
        memreqM = 0; memackM = 1;
        regwriteM = 1; rdM = 5'd6; rs1E = 5'd6;
        #2;
        check("to_hold_fault", 32'(fault), 32'd1);
        chk_ctl("to_hold", 4'b1111, 4'b0001);
        check("to_fwdA", 32'(forwardAE), 32'(FWD_M));
        @(negedge CLK); #2;
        RST = 1'b1;
        #1;
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_state", 32'(dut.state), 32'(RUN));
        chk_ctl("rst_ctl", 4'b0000, 4'b1111);
        @(negedge CLK);
        idle();
        RST = 1'b0;

        // counters: 3 load-use stalls then 2 branch flushes
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            loaduse_in();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            idle();
            pcsrcE = 2'b01;
        end
        @(negedge CLK);
        idle();
        #2;
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stallcnt", stallcnt, 32'd3);
        check("perf_flushcnt", flushcnt, 32'd2);
`else
        check("perf_stallcnt", stallcnt, 32'd0);
        check("perf_flushcnt", flushcnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core; sits beside the F/D/E/M/W pipeline registers.
- Generates the E-stage forwarding selects and load-use stalls, and branch flushes.
- Sequences pipeline freezes for two cases: data-memory wait (handshake) and the multi-cycle mul/div unit.
- A watchdog latches a fault if data memory never acknowledges.

Parameters:
- MEM_TIMEOUT, 255: max consecutive data-memory wait cycles before fault.
- TO_W, 8: timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- rs1D, rs2D  in  5  source registers in D.
- rs1E, rs2E, rdE  in  5  sources/destination in E.
- rdM, rdW  in  5  destinations in M/W.
- regwriteM, regwriteW  in  1  write enables in M/W.
- resultsrcE  in  2  E-stage result select; 2'b01 = load.
- pcsrcE  in  2  non-zero = redirect taken in E.
- memreqM  in  1  load/store active in M.
- memackM  in  1  data memory completes this cycle.
- mdvalidE  in  1  mul/div instruction in E.
- mddone  in  1  mul/div result ready (1-cycle pulse).
- forwardAE, forwardBE  out  2  00 = regfile, 01 = W result, 10 = M ALU result.
- stallF, stallD, stallE, stallM  out  1  hold stage register.
- flushD, flushE, flushM, flushW  out  1  load bubble into stage register.
- mdstart  out  1  1-cycle start pulse to mul/div.
- fault  out  1  sticky memory-timeout fault.
- stallcnt, flushcnt  out  32  performance counters (see Optional Feature).

Behaviour:
- States: RUN, MEMWAIT, MDWAIT, FAULT.
- Registered: state, timeout counter, fault, counters. All other outputs are combinational from state and inputs, with no added latency.
- Reset (async): state=RUN, counters=0, fault=0. While RST is high: all stalls=0, flushD=flushE=flushM=flushW=1, forwards=00, mdstart=0.
- Forwarding (all states):
  - forwardAE=10 if regwriteM && rdM!=0 && rdM==rs1E.
  - Else forwardAE=01 if regwriteW && rdW!=0 && rdW==rs1E.
  - Else forwardAE=00.
  - forwardBE uses rs2E with the same rules. M takes priority over W.
- memstall = memreqM && !memackM.
- RUN:
  - If memstall: freeze (all four stalls=1, flushW=1, flushD=flushE=0, pcsrcE ignored); next state MEMWAIT, timeout counter=1.
  - Else if mdvalidE: mdstart=1, stallF/D/E=1, flushM=1; next state MDWAIT.
  - Else if pcsrcE!=0: flushD=flushE=1, no stall. This overrides load-use.
  - Else if loaduse (resultsrcE==01 && rdE!=0 && (rdE==rs1D || rdE==rs2D)): stallF=stallD=1, flushE=1.
- MEMWAIT:
  - Freeze as above while memstall; counter increments.
  - When memackM=1: release this cycle, i.e. the RUN rules apply to the remaining inputs except mdstart/MDWAIT entry is allowed. Next state RUN or MDWAIT per the RUN rules.
  - When the counter reaches MEM_TIMEOUT with no ack: go to FAULT.
- MDWAIT:
  - stallF/D/E=1, flushM=1, mdstart=0 until mddone.
  - On mddone: all stalls=0 this cycle; E advances at the next edge; next state RUN.
  - mddone while in RUN is ignored.
- FAULT: all stalls=1, flushW=1, fault=1; held until RST.
- Simultaneous memstall and mdvalidE: memory first (older instruction); mdstart is not issued until the memory ack.
- A loaduse hazard on x0 never stalls.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stallcnt increments every cycle any stall is 1.
  - flushcnt increments on each branch flush (pcsrcE!=0 in RUN, not frozen).
  - Both wrap at 2^32 and reset to 0.
- Undefined: counter logic is absent and both ports are tied to 0.

Decomposition:
- hazard_pkg:
  - state enum.
  - FWD_RF/FWD_W/FWD_M select constants.
  - RESULTSRC_LOAD=2'b01.
- One sub-module, hazard_fwd_unit: combinational forwarding for one operand, instantiated twice.

Test Plan:
- rdM=5, regwriteM=1, rdW=5, regwriteW=1, rs1E=5 -> forwardAE=10; with rdM=0 instead -> forwardAE=01.
- Load in E with rdE=3, rs2D=3 -> one cycle of stallF=stallD=1, flushE=1; the same case with pcsrcE=01 -> flushD=flushE=1, stalls=0.
- memreqM=1 with memackM low for 4 cycles -> 4 freeze cycles with flushW=1; on the ack cycle stalls=0 and state=RUN.
- mdvalidE=1, then mddone 6 cycles later -> mdstart high for exactly 1 cycle, 6 cycles of stallF/D/E plus flushM; released in the mddone cycle.
- MEM_TIMEOUT=8, memackM never asserted -> FAULT after 8 wait cycles with fault=1 held; assert RST mid-fault -> all state and fault cleared asynchronously.
- HAZARD_PERF_CNT_EN defined, 3 stall cycles plus 2 branch flushes -> stallcnt=3, flushcnt=2; undefined -> both read 0.
